// File: rtl/otter_pkg.sv
// otter_pkg: shared types and constants for the OTTER fetch unit.
//   pc_src_t      - encoding of the PC_SRC select from the EX stage
//   fetch_state_t - fetch FSM states
//   NOP_INSTR_DEFAULT - bubble instruction (addi x0,x0,0)
//   word_align()  - clears the two low address bits of a target
package otter_pkg;

    typedef enum logic [2:0] {
        PC_SRC_SEQ    = 3'b000,
        PC_SRC_JALR   = 3'b001,
        PC_SRC_BRANCH = 3'b010,
        PC_SRC_JAL    = 3'b011,
        PC_SRC_INTR   = 3'b100,
        PC_SRC_MRET   = 3'b101
    } pc_src_t;

    typedef enum logic [1:0] {
        StIssue,
        StWait,
        StDrain
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/otter_fetch_skid.sv
// otter_fetch_skid: one-entry {pc, ir} holding buffer between instruction memory
// and the IF/ID register.
//   clk_i, rst_i     - clock, synchronous active-high reset
//   load_i           - capture pc_i/ir_i (wins over unload_i)
//   unload_i         - entry consumed by IF/ID
//   clear_i          - discard the entry (wrong path)
//   pc_i, ir_i       - entry to capture
//   valid_o, pc_o, ir_o - buffered entry
module otter_fetch_skid (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        unload_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] ir_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] ir_o
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
        end else if (unload_i) begin
            valid_q <= 1'b0;
        end
    end

    // Payload needs no reset: it is only observed while valid_q is set.
    always_ff @(posedge clk_i) begin
        if (load_i) begin
            pc_q <= pc_i;
            ir_q <= ir_i;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign ir_o    = ir_q;

endmodule

// File: rtl/otter_fetch_unit.sv
// otter_fetch_unit: PC register, single-outstanding instruction fetch, IF/ID
// register with a one-entry skid buffer, and redirect/flush handling.
//   CLK, RST              - clock, synchronous active-high reset
//   PC_SRC, EX_VALID      - next-PC select and EX-stage qualifier
//   JALR, BRANCH, JAL     - EX-stage redirect targets
//   MTVEC, MEPC           - trap vector / trap return address
//   STALL                 - hold IF/ID
//   IMEM_REQ, IMEM_ADDR   - request pulse and fetch address
//   IMEM_VALID, IMEM_RDATA - response strobe and instruction
//   IF_ID_PC/IR/VALID     - IF/ID pipeline register
//   FLUSH                 - kill younger stages (same cycle as a redirect)
module otter_fetch_unit
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [2:0]  PC_SRC,
    input  logic        EX_VALID,
    input  logic [31:0] JALR,
    input  logic [31:0] BRANCH,
    input  logic [31:0] JAL,
    input  logic [31:0] MTVEC,
    input  logic [31:0] MEPC,
    input  logic        STALL,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_VALID,
    input  logic [31:0] IMEM_RDATA,
    output logic [31:0] IF_ID_PC,
    output logic [31:0] IF_ID_IR,
    output logic        IF_ID_VALID,
    output logic        FLUSH
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  req_pc_q;
    logic [31:0]  if_id_pc_q;
    logic [31:0]  if_id_ir_q;
    logic         if_id_valid_q;

    logic         redirect;
    logic         redirect_raw;
    logic [31:0]  target_raw;
    logic [31:0]  target;
    logic         issue;
    logic         deliver;
    logic         skid_valid;
    logic [31:0]  skid_pc;
    logic [31:0]  skid_ir;
    logic         skid_load;
    logic         skid_unload;

    // Next-PC select. The interrupt code is honoured without EX_VALID; 110/111
    // fall through to sequential.
    always_comb begin
        redirect_raw = 1'b0;
        target_raw   = 32'h0;
        case (PC_SRC)
            PC_SRC_JALR: begin
                redirect_raw = EX_VALID;
                target_raw   = JALR;
            end
            PC_SRC_BRANCH: begin
                redirect_raw = EX_VALID;
                target_raw   = BRANCH;
            end
            PC_SRC_JAL: begin
                redirect_raw = EX_VALID;
                target_raw   = JAL;
            end
            PC_SRC_INTR: begin
                redirect_raw = 1'b1;
                target_raw   = MTVEC;
            end
            PC_SRC_MRET: begin
                redirect_raw = EX_VALID;
                target_raw   = MEPC;
            end
            default: ;
        endcase
    end

    assign redirect = redirect_raw & ~RST;
    assign target   = word_align(target_raw);

    // A full skid blocks new requests, which is what keeps one entry enough.
    assign issue   = (state_q == StIssue) & ~redirect & ~skid_valid & ~RST;
    assign deliver = (state_q == StWait) & IMEM_VALID & ~redirect & ~RST;

    assign skid_load   = deliver & (STALL | skid_valid);
    assign skid_unload = ~redirect & ~STALL & skid_valid;

    otter_fetch_skid u_skid (
        .clk_i    (CLK),
        .rst_i    (RST),
        .load_i   (skid_load),
        .unload_i (skid_unload),
        .clear_i  (redirect),
        .pc_i     (req_pc_q),
        .ir_i     (IMEM_RDATA),
        .valid_o  (skid_valid),
        .pc_o     (skid_pc),
        .ir_o     (skid_ir)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= StIssue;
            pc_q          <= RESET_VEC;
            req_pc_q      <= 32'h0;
            if_id_pc_q    <= 32'h0;
            if_id_ir_q    <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIssue: begin
                    if (redirect) begin
                        pc_q <= target;
                    end else if (!skid_valid) begin
                        req_pc_q <= pc_q;
                        pc_q     <= pc_q + 32'd4;
                        state_q  <= StWait;
                    end
                end
                StWait: begin
                    if (redirect) begin
                        pc_q    <= target;
                        // Response still in flight must be drained first.
                        state_q <= IMEM_VALID ? StIssue : StDrain;
                    end else if (IMEM_VALID) begin
                        state_q <= StIssue;
                    end
                end
                StDrain: begin
                    if (redirect) begin
                        pc_q <= target;
                    end
                    if (IMEM_VALID) begin
                        state_q <= StIssue;
                    end
                end
                default: state_q <= StIssue;
            endcase

            if (redirect) begin
                if_id_valid_q <= 1'b0;
                if_id_ir_q    <= NOP_INSTR;
            end else if (STALL) begin
                // hold
            end else if (skid_valid) begin
                if_id_pc_q    <= skid_pc;
                if_id_ir_q    <= skid_ir;
                if_id_valid_q <= 1'b1;
            end else if (deliver) begin
                if_id_pc_q    <= req_pc_q;
                if_id_ir_q    <= IMEM_RDATA;
                if_id_valid_q <= 1'b1;
            end else begin
                if_id_valid_q <= 1'b0;
                if_id_ir_q    <= NOP_INSTR;
            end
        end
    end

    assign IMEM_REQ    = issue;
    assign IMEM_ADDR   = pc_q;
    assign FLUSH       = redirect;
    assign IF_ID_PC    = if_id_pc_q;
    assign IF_ID_IR    = if_id_ir_q;
    assign IF_ID_VALID = if_id_valid_q;

endmodule

// File: doc/otter_fetch_unit.md
Name: otter_fetch_unit

Overview:
- Consumer end of the PC_SRC/target-address interface: takes the 3-bit PC_SRC select and the JALR/BRANCH/JAL targets from the branch condition/address generator (EX stage), plus MTVEC/MEPC from the CSR file.
- Owns the PC register and issues instruction-memory requests, one outstanding at a time.
- Drains or discards wrong-path responses and loads the IF/ID pipeline register, with a one-entry skid buffer for stalls.
- Emits FLUSH to kill younger stages on every redirect.

Parameters:
- RESET_VEC, 32'h0000_0000, PC loaded on reset.
- NOP_INSTR, 32'h0000_0013, IF_ID_IR value for bubbles (addi x0,x0,0).

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- PC_SRC  in  3  000 seq, 001 JALR, 010 BRANCH, 011 JAL, 100 interrupt(MTVEC), 101 mret(MEPC).
- EX_VALID  in  1  EX-stage instruction valid; qualifies codes 001–011 and 101.
- JALR, BRANCH, JAL  in  32 each  redirect targets.
- MTVEC, MEPC  in  32 each  trap vector / return address.
- STALL  in  1  hazard unit holds IF/ID.
- IMEM_REQ  out  1  single-cycle request pulse.
- IMEM_ADDR  out  32  fetch address; valid only while IMEM_REQ=1.
- IMEM_VALID  in  1  single-cycle response strobe, at least 1 cycle after its request.
- IMEM_RDATA  in  32  instruction; valid with IMEM_VALID.
- IF_ID_PC  out  32  PC of the held instruction.
- IF_ID_IR  out  32  held instruction.
- IF_ID_VALID  out  1  IF/ID holds a real instruction.
- FLUSH  out  1  combinational; equals redirect.

Behaviour:
- Redirect (combinational):
  - redirect = (PC_SRC==100) | (EX_VALID & PC_SRC∈{001,010,011,101}).
  - 100 is honoured without EX_VALID. Codes 110/111 are treated as 000: no redirect.
  - target = mux(PC_SRC); bits [1:0] are forced to 00 on every target.
- Reset: on any cycle with RST=1:
  - pc_q=RESET_VEC, state=ISSUE, skid empty.
  - IF_ID_VALID=0, IF_ID_IR=NOP_INSTR, IF_ID_PC=0.
  - IMEM_REQ=0, FLUSH=0.
  - RST mid-WAIT abandons the outstanding request. The response must be returned by memory before the first post-reset request, or it is accepted as the RESET_VEC fetch; the memory model guarantees this.
- FSM states ISSUE, WAIT, DRAIN:
  - ISSUE:
    - redirect → pc_q<=target, no request, stay ISSUE.
    - else if skid empty → IMEM_REQ=1, IMEM_ADDR=pc_q, req_pc<=pc_q, pc_q<=pc_q+4 (wraps mod 2^32), → WAIT.
    - skid full → no request.
  - WAIT:
    - redirect & IMEM_VALID → response dropped, pc_q<=target, → ISSUE.
    - redirect & !IMEM_VALID → pc_q<=target, → DRAIN.
    - IMEM_VALID (no redirect) → response delivered (below), → ISSUE.
  - DRAIN:
    - IMEM_VALID → response dropped, → ISSUE.
    - Further redirects update pc_q, stay DRAIN.
- Response delivery, same edge as IMEM_VALID:
  - !STALL & skid empty → IF/ID <= {req_pc, RDATA, 1}.
  - STALL, or skid occupied → skid <= {req_pc, RDATA}.
- IF/ID update each cycle:
  - redirect (overrides STALL) → IF_ID_VALID<=0, IR<=NOP_INSTR, and the skid is cleared.
  - STALL → hold.
  - else skid valid → load skid, skid empties.
  - else response delivered → load it.
  - else → bubble (VALID=0, IR=NOP_INSTR).
- Throughput: 2 cycles per instruction minimum (request, response); 1-cycle memory latency gives IMEM_REQ every other cycle.
- Redirect-to-request latency: 1 cycle from ISSUE, or after the drain.
- Skid depth 1 suffices because no request issues while the skid is full.
- Invariants:
  - Never more than one request outstanding.
  - IMEM_REQ never asserted in WAIT or DRAIN.

Decomposition:
- Shared package otter_pkg holds:
  - typedef pc_src_t (PC_SRC_SEQ…PC_SRC_MRET).
  - typedef fetch_state_t.
  - Constant NOP_INSTR default.
- One sub-module, otter_fetch_skid: a 1-entry {pc,ir} buffer with load/unload/clear.
- The next-PC mux stays inline.

Test Plan:
- Reset release, 1-cycle memory returning 0x00000013 → IMEM_ADDR sequence 0,4,8 on cycles 1,3,5; IF_ID_PC 0,4,8 with VALID=1.
- EX_VALID=1, PC_SRC=010, BRANCH=0x100 while in WAIT (memory latency 3) → FLUSH=1 that cycle; the late response for 0x8 is dropped; next IMEM_ADDR=0x100; IF_ID_VALID=0 until 0x100 arrives.
- PC_SRC=001, JALR=0x203 → IMEM_ADDR=0x200.
- PC_SRC=100, EX_VALID=0, MTVEC=0x80 → redirect taken, IMEM_ADDR=0x80.
- PC_SRC=101, MEPC=0x44 → IMEM_ADDR=0x44.
- PC_SRC=011 with EX_VALID=0, and PC_SRC=110 with EX_VALID=1 → no FLUSH, sequential fetch continues.
- STALL held 4 cycles while response 0xC arrives → IF/ID holds its old instruction, 0xC goes to the skid, no IMEM_REQ; STALL drops → IF_ID_PC=0xC next cycle, then requests resume.
- RST asserted mid-WAIT → next cycle all outputs at reset values; first post-reset IMEM_ADDR=RESET_VEC.
